hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage mini CPU. Generates every stall and flush enable for the fetch PC register, the IF/ID, ID/EX and EX/MEM pipeline registers. Drives the `pcStall` / `pcFromTaken` pair that selects the next PC in the PC generator. Resolves load-use hazards, branch/jump redirects and multi-cycle instruction/data memory waits through a small FSM, and keeps stall/flush performance counters.

## Interface
- No parameters; widths fixed (XLEN 32, register index 5).
- `clk  in  1`: rising-edge clock.
- `reset_n  in  1`: asynchronous, active-low reset.
- `id_rs1`, `id_rs2  in  5 each`: source registers of the instruction in ID.
- `id_rs1_used`, `id_rs2_used  in  1 each`: source actually read.
- `ex_rd  in  5`: destination register of the instruction in EX.
- `ex_mem_read  in  1`: EX instruction is a load.
- `ex_branch  in  1`: EX instruction is a conditional branch.
- `ex_cond  in  1`: branch condition, `alu_result[0]`.
- `ex_jump  in  2`: `[1]` = jalr, `[0]` = jal.
- `ex_pred_taken  in  1`: fetch predicted taken for the EX instruction.
- `imem_ready  in  1`: instruction fetch completes this cycle.
- `mem_req  in  1`: MEM-stage load/store active.
- `dmem_ready  in  1`: data access completes this cycle.
- `pc_stall  out  1`: hold the PC register.
- `pc_from_taken  out  1`: take the EX-resolved target instead of `pre_pc`.
- `if_id_stall`, `id_ex_stall`, `ex_mem_stall  out  1 each`: hold the named register.
- `if_id_flush`, `id_ex_flush  out  1 each`: load a bubble into the named register.
- `stall_cnt`, `flush_cnt  out  32 each`: performance counters.

## Operation
- States: RUN, DWAIT, DISCARD.
- Definitions:
  - `actual_taken = ex_jump != 0 | (ex_branch & ex_cond)`.
  - `redirect = actual_taken != ex_pred_taken`. A predicted-taken branch that is not taken also redirects, to PC+4.
  - `load_use = ex_mem_read & ex_rd != 0 & ((id_rs1_used & id_rs1 == ex_rd) | (id_rs2_used & id_rs2 == ex_rd))`.
- RUN, evaluated in priority order:
  1. `mem_req & !dmem_ready`: assert all four stalls; go to DWAIT.
  2. `redirect`: assert `pc_from_taken`, `if_id_flush` and `id_ex_flush`. If `!imem_ready`, also go to DISCARD.
  3. `load_use`: assert `pc_stall` and `if_id_stall` and `id_ex_flush` (one bubble).
  4. `!imem_ready`: assert `pc_stall` and `if_id_flush` (fetch bubble).
- DWAIT:
  - All four stalls held; nothing else is evaluated, so a pending redirect or load-use stays frozen in EX/ID.
  - On `dmem_ready`, drop the stalls in that same cycle and return to RUN.
- DISCARD:
  - The fetch outstanding at the redirect belongs to the wrong path.
  - Hold `pc_stall` and `if_id_flush` until `imem_ready`. The returning word is flushed; go to RUN.
  - `pc_stall` in DISCARD keeps the redirect target already loaded into PC.
  - A data wait (`mem_req & !dmem_ready`) in DISCARD also asserts `id_ex_stall` and `ex_mem_stall`, and stays in DISCARD.
- Flush wins over stall on the same register: `if_id_flush` overrides `if_id_stall`.
- Counters:
  - `stall_cnt` increments in every cycle with `pc_stall` = 1.
  - `flush_cnt` increments in every cycle with `id_ex_flush` = 1.
  - Both wrap modulo 2^32.

## Timing
- Stall/flush/`pc_from_taken` outputs are combinational from the inputs and the current state; they act at the next clock edge.
- Only the state and counters are registered.
- Redirect penalty: 2 bubbles (IF/ID, ID/EX), plus DISCARD cycles when the fetch is pending.
- Load-use penalty: exactly 1 cycle; the condition clears once the bubble occupies EX.
- DWAIT exit has zero added latency after `dmem_ready`.
- Reset (async, any state, including mid-DWAIT or mid-DISCARD): state = RUN, counters = 0. All outputs are then the RUN-state combinational value; with quiet inputs all outputs are 0.

## Structure
- Shared package `cpu_defs`: state encoding (RUN = 2'd0, DWAIT = 2'd1, DISCARD = 2'd2), `JUMP_JALR` / `JUMP_JAL` bit indices, `XLEN`, register-index width.
- One sub-module `hazard_detect`: purely combinational `load_use` / `redirect` decode.
- FSM, output mux and counters stay in `hazard_ctrl`.

## Test plan
- Load-use: lw x5 in EX, `id_rs1` = 5, used. Expect `pc_stall` = `if_id_stall` = `id_ex_flush` = 1 for one cycle, then 0; `stall_cnt` = 1.
- Load writing x0: `ex_rd` = 0 with matching rs1 = 0 → no stall.
- Mispredicted branch: `ex_branch` = 1, `ex_cond` = 1, `ex_pred_taken` = 0, `imem_ready` = 1. Expect `pc_from_taken` = `if_id_flush` = `id_ex_flush` = 1 for one cycle; `flush_cnt` = 1.
- Redirect with `imem_ready` = 0 for 3 cycles. Expect DISCARD, `pc_stall` and `if_id_flush` held 3 cycles, and the returning word flushed.
- Data wait: `mem_req` = 1, `dmem_ready` low 4 cycles while a jalr sits in EX. Expect all stalls for 4 cycles and no `pc_from_taken`, then `pc_from_taken` in the cycle after `dmem_ready`.
- Reset asserted mid-DWAIT. Expect state RUN and counters 0 immediately (asynchronous). After release with quiet inputs, all outputs 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared CPU definitions: datapath widths, jump-field bit positions and
// the hazard controller state encoding.
package cpu_defs;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  // Bit positions inside the two-bit ex_jump field
  localparam int unsigned JUMP_JALR = 1;
  localparam int unsigned JUMP_JAL  = 0;

  typedef logic [REG_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]  word_t;

  // Controller state encoding, kept as fixed constants so the values match
  // the legacy waveforms and debug scripts.
  typedef logic [1:0] hz_state_t;
  localparam hz_state_t ST_RUN     = 2'd0;
  localparam hz_state_t ST_DWAIT   = 2'd1;
  localparam hz_state_t ST_DISCARD = 2'd2;

  // Bundle of every stall/flush/select control driven by the controller
  typedef struct packed {
    logic pc_stall;
    logic pc_from_taken;
    logic if_id_stall;
    logic id_ex_stall;
    logic ex_mem_stall;
    logic if_id_flush;
    logic id_ex_flush;
  } hz_ctrl_t;

  // True when the register written by EX is a real (non-x0) source of ID
  function automatic logic src_match(input reg_idx_t rs, input logic used,
                                     input reg_idx_t rd);
    return used && (rs == rd) && (rd != '0);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle. The pipeline (master)
// supplies stage information and memory handshakes; the controller
// (slave) returns stall/flush enables and performance counters.
interface hazard_ctrl_if;
  import cpu_defs::*;

  reg_idx_t   id_rs1;
  reg_idx_t   id_rs2;
  logic       id_rs1_used;
  logic       id_rs2_used;
  reg_idx_t   ex_rd;
  logic       ex_mem_read;
  logic       ex_branch;
  logic       ex_cond;
  logic [1:0] ex_jump;
  logic       ex_pred_taken;
  logic       imem_ready;
  logic       mem_req;
  logic       dmem_ready;

  logic       pc_stall;
  logic       pc_from_taken;
  logic       if_id_stall;
  logic       id_ex_stall;
  logic       ex_mem_stall;
  logic       if_id_flush;
  logic       id_ex_flush;
  word_t      stall_cnt;
  word_t      flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
           ex_branch, ex_cond, ex_jump, ex_pred_taken, imem_ready,
           mem_req, dmem_ready,
    input  pc_stall, pc_from_taken, if_id_stall, id_ex_stall, ex_mem_stall,
           if_id_flush, id_ex_flush, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
           ex_branch, ex_cond, ex_jump, ex_pred_taken, imem_ready,
           mem_req, dmem_ready,
    output pc_stall, pc_from_taken, if_id_stall, id_ex_stall, ex_mem_stall,
           if_id_flush, id_ex_flush, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_ctrl_detect.sv
// Purely combinational hazard decode: load-use dependency between EX and
// ID, and branch/jump outcome disagreeing with the fetch prediction.
module hazard_detect
  import cpu_defs::*;
(
  input  reg_idx_t   id_rs1,
  input  reg_idx_t   id_rs2,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  reg_idx_t   ex_rd,
  input  logic       ex_mem_read,
  input  logic       ex_branch,
  input  logic       ex_cond,
  input  logic [1:0] ex_jump,
  input  logic       ex_pred_taken,
  output logic       load_use,
  output logic       redirect
);

  logic actual_taken;

  // Resolve the real control-flow outcome and compare with prediction;
  // a predicted-taken branch that falls through also redirects (to PC+4).
  always_comb begin
    actual_taken = ex_jump[JUMP_JALR] | ex_jump[JUMP_JAL] | (ex_branch & ex_cond);
    redirect     = actual_taken != ex_pred_taken;
  end

  // Load in EX producing a register that ID reads this cycle
  always_comb begin
    load_use = ex_mem_read &
               (src_match(id_rs1, id_rs1_used, ex_rd) |
                src_match(id_rs2, id_rs2_used, ex_rd));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and sequencing controller: RUN / DWAIT / DISCARD FSM,
// stall/flush output mux and stall/flush performance counters.
module hazard_ctrl
  import cpu_defs::*;
(
  input  logic         clk,
  input  logic         reset_n,
  hazard_ctrl_if.slave hz
);

  hz_state_t state;
  hz_state_t state_nxt;
  hz_ctrl_t  ctl;
  logic      load_use;
  logic      redirect;
  logic      data_wait;

  hazard_detect u_detect (
    .id_rs1        (hz.id_rs1),
    .id_rs2        (hz.id_rs2),
    .id_rs1_used   (hz.id_rs1_used),
    .id_rs2_used   (hz.id_rs2_used),
    .ex_rd         (hz.ex_rd),
    .ex_mem_read   (hz.ex_mem_read),
    .ex_branch     (hz.ex_branch),
    .ex_cond       (hz.ex_cond),
    .ex_jump       (hz.ex_jump),
    .ex_pred_taken (hz.ex_pred_taken),
    .load_use      (load_use),
    .redirect      (redirect)
  );

  assign data_wait = hz.mem_req & ~hz.dmem_ready;

  // Next-state and raw control decode for the current state
  always_comb begin
    ctl       = '0;
    state_nxt = state;
    unique case (state)
      ST_RUN: begin
        if (data_wait) begin
          ctl.pc_stall     = 1'b1;
          ctl.if_id_stall  = 1'b1;
          ctl.id_ex_stall  = 1'b1;
          ctl.ex_mem_stall = 1'b1;
          state_nxt        = ST_DWAIT;
        end else if (redirect) begin
          ctl.pc_from_taken = 1'b1;
          ctl.if_id_flush   = 1'b1;
          ctl.id_ex_flush   = 1'b1;
          if (!hz.imem_ready) state_nxt = ST_DISCARD;
        end else if (load_use) begin
          ctl.pc_stall    = 1'b1;
          ctl.if_id_stall = 1'b1;
          ctl.id_ex_flush = 1'b1;
        end else if (!hz.imem_ready) begin
          ctl.pc_stall    = 1'b1;
          ctl.if_id_flush = 1'b1;
        end
      end
      ST_DWAIT: begin
        // Pipeline frozen; stalls drop in the very cycle dmem_ready arrives
        if (hz.dmem_ready) begin
          state_nxt = ST_RUN;
        end else begin
          ctl.pc_stall     = 1'b1;
          ctl.if_id_stall  = 1'b1;
          ctl.id_ex_stall  = 1'b1;
          ctl.ex_mem_stall = 1'b1;
        end
      end
      ST_DISCARD: begin
        // PC already holds the redirect target; keep it until the stale
        // fetch returns, and flush that wrong-path word on arrival.
        ctl.pc_stall    = 1'b1;
        ctl.if_id_flush = 1'b1;
        if (data_wait) begin
          ctl.id_ex_stall  = 1'b1;
          ctl.ex_mem_stall = 1'b1;
        end else if (hz.imem_ready) begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Drive interface outputs; a flush on IF/ID overrides its stall
  always_comb begin
    hz.pc_stall      = ctl.pc_stall;
    hz.pc_from_taken = ctl.pc_from_taken;
    hz.if_id_stall   = ctl.if_id_stall & ~ctl.if_id_flush;
    hz.id_ex_stall   = ctl.id_ex_stall;
    hz.ex_mem_stall  = ctl.ex_mem_stall;
    hz.if_id_flush   = ctl.if_id_flush;
    hz.id_ex_flush   = ctl.id_ex_flush;
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_RUN;
    else          state <= state_nxt;
  end

  // Performance counters, free-running and wrapping at 2^32
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hz.stall_cnt <= '0;
      hz.flush_cnt <= '0;
    end else begin
      if (ctl.pc_stall)    hz.stall_cnt <= hz.stall_cnt + 1'b1;
      if (ctl.id_ex_flush) hz.flush_cnt <= hz.flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver applies directed vectors and
// queues hand-computed expectations; a monitor pops and compares.
module tb_hazard_ctrl;

  // Output bit order: pc_stall, pc_from_taken, if_id_stall, id_ex_stall,
  // ex_mem_stall, if_id_flush, id_ex_flush
  localparam logic [6:0] O_NONE  = 7'b0000000;
  localparam logic [6:0] O_LU    = 7'b1010001;
  localparam logic [6:0] O_RDIR  = 7'b0100011;
  localparam logic [6:0] O_FBUB  = 7'b1000010;
  localparam logic [6:0] O_DWAIT = 7'b1011100;
  localparam logic [6:0] O_DDISC = 7'b1001110;

  typedef struct {
    string       name;
    logic [6:0]  o;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  logic clk;
  logic reset_n;
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  logic [31:0] exp_sc = '0;
  logic [31:0] exp_fc = '0;

  hazard_ctrl_if hz();

  hazard_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .hz      (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input string nm,
                      input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2,
                      input logic [4:0] rd,  input logic mr,
                      input logic br, input logic cnd, input logic [1:0] jmp,
                      input logic pred, input logic im, input logic mq,
                      input logic dr, input logic rst, input logic [6:0] eo);
    exp_t e;
    @(negedge clk);
    hz.id_rs1 = rs1;  hz.id_rs1_used = u1;
    hz.id_rs2 = rs2;  hz.id_rs2_used = u2;
    hz.ex_rd = rd;    hz.ex_mem_read = mr;
    hz.ex_branch = br; hz.ex_cond = cnd; hz.ex_jump = jmp;
    hz.ex_pred_taken = pred;
    hz.imem_ready = im; hz.mem_req = mq; hz.dmem_ready = dr;
    reset_n = rst;
    if (!rst) begin
      exp_sc = '0;
      exp_fc = '0;
    end
    e.name = nm; e.o = eo; e.sc = exp_sc; e.fc = exp_fc;
    sb.push_back(e);
    if (rst) begin
      exp_sc = exp_sc + {31'd0, eo[6]};
      exp_fc = exp_fc + {31'd0, eo[0]};
    end
  endtask

  task automatic quiet(input string nm, input logic [6:0] eo);
    step(nm, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00,
         1'b0, 1'b1, 1'b0, 1'b1, 1'b1, eo);
  endtask

  // Monitor: compare outputs and counters well after the inputs settle
  initial begin
    exp_t e;
    logic [6:0] act;
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        act = {hz.pc_stall, hz.pc_from_taken, hz.if_id_stall, hz.id_ex_stall,
               hz.ex_mem_stall, hz.if_id_flush, hz.id_ex_flush};
        checks++;
        if (act !== e.o) begin
          failures++;
          $display("FAIL %s ctl: got %b expected %b", e.name, act, e.o);
        end
        checks++;
        if (hz.stall_cnt !== e.sc) begin
          failures++;
          $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, hz.stall_cnt, e.sc);
        end
        checks++;
        if (hz.flush_cnt !== e.fc) begin
          failures++;
          $display("FAIL %s flush_cnt: got %0d expected %0d", e.name, hz.flush_cnt, e.fc);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_rs1_used = 1'b0; hz.id_rs2_used = 1'b0;
    hz.ex_rd = '0; hz.ex_mem_read = 1'b0; hz.ex_branch = 1'b0; hz.ex_cond = 1'b0;
    hz.ex_jump = 2'b00; hz.ex_pred_taken = 1'b0;
    hz.imem_ready = 1'b1; hz.mem_req = 1'b0; hz.dmem_ready = 1'b1;

    //    name         rs1  u1  rs2  u2  rd  mr br cn jmp  pr im mq dr rst  expected
    step("reset",      0,   0,  0,   0,  0,  0, 0, 0, 2'b00, 0, 1, 0, 1, 0, O_NONE);
    quiet("idle", O_NONE);
    // Load-use on rs1, one bubble then clear
    step("lu_rs1",     5,   1,  0,   0,  5,  1, 0, 0, 2'b00, 0, 1, 0, 1, 1, O_LU);
    quiet("lu_after", O_NONE);
    step("lu_rs2",     0,   0,  7,   1,  7,  1, 0, 0, 2'b00, 0, 1, 0, 1, 1, O_LU);
    step("rs2_unused", 0,   0,  7,   0,  7,  1, 0, 0, 2'b00, 0, 1, 0, 1, 1, O_NONE);
    step("load_x0",    0,   1,  0,   0,  0,  1, 0, 0, 2'b00, 0, 1, 0, 1, 1, O_NONE);
    step("not_load",   5,   1,  0,   0,  5,  0, 0, 0, 2'b00, 0, 1, 0, 1, 1, O_NONE);
    // Branch outcomes versus prediction
    step("br_mispred", 0,   0,  0,   0,  0,  0, 1, 1, 2'b00, 0, 1, 0, 1, 1, O_RDIR);
    step("br_pred_nt", 0,   0,  0,   0,  0,  0, 1, 0, 2'b00, 1, 1, 0, 1, 1, O_RDIR);
    step("br_pred_ok", 0,   0,  0,   0,  0,  0, 1, 1, 2'b00, 1, 1, 0, 1, 1, O_NONE);
    step("rdir_vs_lu", 3,   1,  0,   0,  3,  1, 0, 0, 2'b01, 0, 1, 0, 1, 1, O_RDIR);
    // Fetch bubble and its priority below load-use
    quiet("fetch_wait_off", O_NONE);
    step("fetch_bub",  0,   0,  0,   0,  0,  0, 0, 0, 2'b00, 0, 0, 0, 1, 1, O_FBUB);
    step("lu_vs_fbub", 9,   1,  0,   0,  9,  1, 0, 0, 2'b00, 0, 0, 0, 1, 1, O_LU);
    // Redirect with pending fetch: DISCARD for three more cycles
    step("jal_rdir",   0,   0,  0,   0,  0,  0, 0, 0, 2'b01, 0, 0, 0, 1, 1, O_RDIR);
    step("disc_1",     0,   0,  0,   0,  0,  0, 0, 0, 2'b00, 0, 0, 0, 1, 1, O_FBUB);
    step("disc_2",     0,   0,  0,   0,  0,  0, 0, 0, 2'b00, 0, 0, 0, 1, 1, O_FBUB);
    step("disc_ret",   0,   0,  0,   0,  0,  0, 0, 0, 2'b00, 0, 1, 0, 1, 1, O_FBUB);
    quiet("disc_done", O_NONE);
    // Data wait while in DISCARD
    step("jal_rdir2",  0,   0,  0,   0,  0,  0, 0, 0, 2'b01, 0, 0, 0, 1, 1, O_RDIR);
    step("disc_dwait", 0,   0,  0,   0,  0,  0, 0, 0, 2'b00, 0, 0, 1, 0, 1, O_DDISC);
    step("disc_dwait2",0,   0,  0,   0,  0,  0, 0, 0, 2'b00, 0, 0, 1, 0, 1, O_DDISC);
    step("disc_ret2",  0,   0,  0,   0,  0,  0, 0, 0, 2'b00, 0, 1, 1, 1, 1, O_FBUB);
    quiet("disc_done2", O_NONE);
    // Data wait with a jalr frozen in EX
    step("dw_1",       0,   0,  0,   0,  0,  0, 0, 0, 2'b10, 0, 1, 1, 0, 1, O_DWAIT);
    step("dw_2",       0,   0,  0,   0,  0,  0, 0, 0, 2'b10, 0, 1, 1, 0, 1, O_DWAIT);
    step("dw_3",       0,   0,  0,   0,  0,  0, 0, 0, 2'b10, 0, 1, 1, 0, 1, O_DWAIT);
    step("dw_4",       0,   0,  0,   0,  0,  0, 0, 0, 2'b10, 0, 1, 1, 0, 1, O_DWAIT);
    step("dw_ready",   0,   0,  0,   0,  0,  0, 0, 0, 2'b10, 0, 1, 1, 1, 1, O_NONE);
    step("dw_jalr",    0,   0,  0,   0,  0,  0, 0, 0, 2'b10, 0, 1, 0, 1, 1, O_RDIR);
    quiet("dw_done", O_NONE);
    // Reset mid-DWAIT: RUN decode visible immediately (redirect, not frozen)
    step("rdw_1",      0,   0,  0,   0,  0,  0, 0, 0, 2'b00, 0, 1, 1, 0, 1, O_DWAIT);
    step("rdw_2",      0,   0,  0,   0,  0,  0, 0, 0, 2'b00, 0, 1, 1, 0, 1, O_DWAIT);
    step("rst_mid",    0,   0,  0,   0,  0,  0, 0, 0, 2'b01, 0, 1, 1, 1, 0, O_RDIR);
    step("rst_hold",   0,   0,  0,   0,  0,  0, 0, 0, 2'b00, 0, 1, 0, 1, 0, O_NONE);
    quiet("post_rst", O_NONE);
    quiet("post_rst2", O_NONE);

    @(negedge clk);
    #5;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always terminates
  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish before 20000");
    $fatal(1, "timeout");
  end

endmodule
